// File: rtl/encode_4_2_buf.sv
// 4-to-2 line encoder feeding a two-entry in-order result buffer,
// with a saturating counter of accepted non-one-hot select words.
package encode_4_2_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    typedef struct packed {
        logic [1:0] code;
        logic       legal;
    } res_t;

endpackage

module encode_4_2_buf
    import encode_4_2_buf_pkg::*;
#(
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       code,
    output logic             legal,
    input  logic             clr_err,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_ov
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    occ_t state;
    occ_t state_nxt;
    res_t head;
    res_t head_nxt;
    res_t tail;
    res_t tail_nxt;
    res_t enc;

    logic push;
    logic pop;

    // Encoder: highest set bit wins; legal only for exactly one bit.
    always_comb begin
        enc = '0;
        unique casez (s)
            4'b1???: enc.code = 2'd3;
            4'b01??: enc.code = 2'd2;
            4'b001?: enc.code = 2'd1;
            default: enc.code = 2'd0;
        endcase
        enc.legal = (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

    // Next-state and buffer movement
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_nxt  = enc;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_nxt = enc;
                end else if (push) begin
                    tail_nxt  = enc;
                    state_nxt = FULL;
                end else if (pop) begin
                    head_nxt  = '0;
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_nxt  = tail;
                    tail_nxt  = '0;
                    state_nxt = ONE;
                end
            end
            default: begin
                head_nxt  = '0;
                tail_nxt  = '0;
                state_nxt = EMPTY;
            end
        endcase
    end

    // Outputs: handshake flags depend only on registered state and reset
    always_comb begin
        in_ready  = reset && (state != FULL);
        out_valid = reset && (state != EMPTY);
        code      = out_valid ? head.code : 2'd0;
        legal     = out_valid ? head.legal : 1'b0;
    end

    // Clear beats a simultaneous illegal acceptance
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_cnt <= '0;
            err_ov  <= 1'b0;
        end else if (clr_err) begin
            err_cnt <= '0;
            err_ov  <= 1'b0;
        end else if (push && !enc.legal) begin
            if (err_cnt == ERR_MAX) begin
                err_ov <= 1'b1;
            end else begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_encode_4_2_buf.sv
// Randomized and directed bench for encode_4_2_buf against a
// queue-based reference model.
module tb_encode_4_2_buf;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] s = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] code;
    logic       legal;
    logic       clr_err = 1'b0;
    logic [7:0] err_cnt;
    logic       err_ov;

    int errors = 0;
    int checks = 0;

    // Model state: queue of {legal, code}
    logic [2:0] mq[$];
    int         m_cnt = 0;
    bit         m_ov = 1'b0;

    logic [13:0] obs;
    logic [13:0] exp_v;

    encode_4_2_buf #(.ERR_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .s(s),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .code(code),
        .legal(legal),
        .clr_err(clr_err),
        .err_cnt(err_cnt),
        .err_ov(err_ov)
    );

    always #5 clk = ~clk;

    assign obs = {in_ready, out_valid, code, legal, err_cnt, err_ov};

    function automatic logic [2:0] ref_enc(input logic [3:0] w);
        int ones = 0;
        int hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                ones++;
                hi = i;
            end
        end
        return {ones == 1, 2'(hi)};
    endfunction

    function automatic logic [13:0] model_vec();
        logic ir;
        logic ov;
        logic [2:0] h;
        ir = reset && (mq.size() < 2);
        ov = reset && (mq.size() > 0);
        h = ov ? mq[0] : 3'b000;
        return {ir, ov, h[1:0], h[2], 8'(m_cnt), m_ov};
    endfunction

    task automatic model_edge();
        bit ir;
        bit ov;
        bit push;
        bit pop;
        logic [2:0] e;
        ir = reset && (mq.size() < 2);
        ov = reset && (mq.size() > 0);
        if (!reset) begin
            mq.delete();
            m_cnt = 0;
            m_ov = 1'b0;
        end else begin
            push = in_valid && ir;
            pop = ov && out_ready;
            e = ref_enc(s);
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (clr_err) begin
                m_cnt = 0;
                m_ov = 1'b0;
            end else if (push && !e[2]) begin
                if (m_cnt == 255) m_ov = 1'b1;
                else m_cnt++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        exp_v = model_vec();
    endtask

    task automatic drive(input bit r, input bit iv, input logic [3:0] w,
                         input bit ordy, input bit clr);
        reset = r;
        in_valid = iv;
        s = w;
        out_ready = ordy;
        clr_err = clr;
    endtask

    task automatic apply_reset();
        drive(0, 0, 4'd0, 0, 0);
        cyc();
        cyc();
        drive(1, 0, 4'd0, 0, 0);
    endtask

    task automatic test_reset();
        drive(0, 1, 4'b0100, 1, 0);
        cyc();
        cyc();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_state got=%b want=%b", obs, 14'd0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%b out_valid=%b want 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        apply_reset();
        drive(1, 1, 4'b0100, 1, 0);
        cyc();
        drive(1, 0, 4'd0, 1, 0);
        checks++;
        if ({out_valid, code, legal} !== 4'b1101 || obs !== exp_v) begin
            errors++;
            $display("FAIL single_out got=%b want=%b", obs, exp_v);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("FAIL single_drain got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_full();
        apply_reset();
        drive(1, 1, 4'b0001, 0, 0);
        cyc();
        drive(1, 1, 4'b1000, 0, 0);
        cyc();
        drive(1, 0, 4'd0, 1, 0);
        checks++;
        if ({in_ready, out_valid, code, legal} !== 5'b01001 || obs !== exp_v) begin
            errors++;
            $display("FAIL full_head got=%b want=%b", obs, exp_v);
        end
        cyc();
        checks++;
        if ({in_ready, out_valid, code, legal} !== 5'b11111 || obs !== exp_v) begin
            errors++;
            $display("FAIL full_second got=%b want=%b", obs, exp_v);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("FAIL full_empty got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        drive(1, 1, 4'b0110, 0, 0);
        cyc();
        drive(1, 1, 4'b0000, 1, 0);
        checks++;
        if ({out_valid, code, legal} !== 4'b1100 || obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_0110 got=%b want=%b", obs, exp_v);
        end
        cyc();
        drive(1, 0, 4'd0, 1, 0);
        checks++;
        if ({out_valid, code, legal, err_cnt} !== {4'b1000, 8'd2} || obs !== exp_v) begin
            errors++;
            $display("FAIL illegal_0000 got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        drive(1, 1, 4'b1111, 1, 0);
        for (int i = 0; i < 256; i++) cyc();
        checks++;
        if (err_cnt !== 8'd255 || err_ov !== 1'b1 || obs !== exp_v) begin
            errors++;
            $display("FAIL saturate cnt=%0d ov=%b want 255/1", err_cnt, err_ov);
        end
        drive(1, 1, 4'b1111, 1, 1);
        cyc();
        drive(1, 0, 4'd0, 1, 0);
        checks++;
        if (err_cnt !== 8'd0 || err_ov !== 1'b0 || obs !== exp_v) begin
            errors++;
            $display("FAIL clr_priority cnt=%0d ov=%b want 0/0", err_cnt, err_ov);
        end
    endtask

    task automatic test_one_push_pop();
        apply_reset();
        drive(1, 1, 4'b0001, 0, 0);
        cyc();
        drive(1, 1, 4'b0010, 1, 0);
        cyc();
        drive(1, 0, 4'd0, 0, 0);
        checks++;
        if ({in_ready, out_valid, code, legal} !== 5'b11011 || obs !== exp_v) begin
            errors++;
            $display("FAIL one_push_pop got=%b want=%b", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        drive(1, 1, 4'b0011, 0, 0);
        cyc();
        cyc();
        drive(0, 1, 4'b0100, 1, 0);
        cyc();
        checks++;
        if ({in_ready, out_valid, err_cnt} !== 10'd0 || obs !== exp_v) begin
            errors++;
            $display("FAIL reset_mid got=%b want=%b", obs, exp_v);
        end
        drive(1, 0, 4'd0, 1, 0);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_release in_ready=%b out_valid=%b", in_ready, out_valid);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  4'($urandom),
                  ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 39) == 0));
            cyc();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d got=%b want=%b", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        drive(1, 1, 4'b1111, 0, 0);
        for (int i = 0; i < 300; i++) begin
            s = 4'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            cyc();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back%0d got=%b want=%b", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_illegal();
        test_saturate();
        test_one_push_pop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
